knn_vote: RTL and testbench

Consumer end of the K-nearest-neighbour list produced by the distance/insert datapath. On `start` it snapshots the sorted K-entry neighbour list (`{dist, label}` per entry, nearest first), walks it one entry per cycle to build a per-class vote histogram, then scans the histogram to select the majority class. Ties go to the class seen nearest. The result is presented with a one-cycle `done` pulse to the KNN control/CPU register interface.

---
 rtl/knn_vote.sv | 182 ++++++++++++++++++
 tb/tb_knn_vote.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/knn_vote.sv
// knn_vote: majority-vote classifier over a sorted K-nearest-neighbour list.
// Snapshots the list on start, builds a per-class vote histogram one entry per
// cycle, then scans the classes one per cycle to pick the winner. Ties are
// broken in favour of the class whose first vote came from the nearer entry.
module knn_vote #(
    parameter int DATA_W = 32,
    parameter int C      = 8,
    parameter int K      = 4,
    parameter int NCLASS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [K*(DATA_W+C)-1:0]   nb_list,
    output logic                      busy,
    output logic                      done,
    output logic [C-1:0]              label_out,
    output logic [$clog2(K+1)-1:0]    n_valid,
    output logic                      err
);

    localparam int EW    = DATA_W + C;
    localparam int CNT_W = $clog2(K + 1);
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam int CLS_W = (NCLASS > 1) ? $clog2(NCLASS) : 1;

    localparam logic [C:0]       NCLASS_C = (C + 1)'(NCLASS);
    localparam logic [IDX_W-1:0] LAST_ENT = IDX_W'(K - 1);
    localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NCLASS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_SELECT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [K*EW-1:0]    snap_q;
    logic [CNT_W-1:0]   votes_q [NCLASS];
    logic [IDX_W-1:0]   first_q [NCLASS];
    logic [IDX_W-1:0]   ent_q;
    logic [CLS_W-1:0]   cls_q;
    logic [CLS_W-1:0]   best_cls_q;
    logic [CNT_W-1:0]   best_cnt_q;
    logic [IDX_W-1:0]   best_first_q;
    logic [CNT_W-1:0]   nv_acc_q;
    logic               err_acc_q;
    logic               busy_q;
    logic               done_q;
    logic [C-1:0]       label_q;
    logic [CNT_W-1:0]   n_valid_q;
    logic               err_q;

    // Decoded view of the entry under scan and of the class under selection.
    logic [DATA_W-1:0]  cur_dist;
    logic [C-1:0]       cur_label;
    logic [CLS_W-1:0]   cur_idx;
    logic               cur_empty;
    logic               cur_valid;
    logic [CNT_W-1:0]   sel_votes;
    logic [IDX_W-1:0]   sel_first;
    logic               sel_take;
    logic [CLS_W-1:0]   best_cls_d;
    logic [CNT_W-1:0]   best_cnt_d;
    logic [IDX_W-1:0]   best_first_d;

    // The snapshot shifts up one entry per SCAN cycle, so the current entry
    // always sits in the top slot; the selection compare feeds the trackers.
    always_comb begin
        cur_dist     = snap_q[K*EW-1 -: DATA_W];
        cur_label    = snap_q[(K-1)*EW +: C];
        cur_idx      = CLS_W'(cur_label);
        cur_empty    = &cur_dist;
        cur_valid    = !cur_empty && ({1'b0, cur_label} < NCLASS_C);
        sel_votes    = votes_q[cls_q];
        sel_first    = first_q[cls_q];
        sel_take     = (sel_votes > best_cnt_q) ||
                       ((sel_votes == best_cnt_q) && (sel_votes != '0) &&
                        (sel_first < best_first_q));
        best_cls_d   = sel_take ? cls_q     : best_cls_q;
        best_cnt_d   = sel_take ? sel_votes : best_cnt_q;
        best_first_d = sel_take ? sel_first : best_first_q;
    end

    // Control FSM with histogram, trackers and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            snap_q       <= '0;
            for (int i = 0; i < NCLASS; i++) begin
                votes_q[i] <= '0;
                first_q[i] <= '0;
            end
            ent_q        <= '0;
            cls_q        <= '0;
            best_cls_q   <= '0;
            best_cnt_q   <= '0;
            best_first_q <= '0;
            nv_acc_q     <= '0;
            err_acc_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            label_q      <= '0;
            n_valid_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        snap_q    <= nb_list;
                        err_q     <= 1'b0;
                        n_valid_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    for (int i = 0; i < NCLASS; i++) begin
                        votes_q[i] <= '0;
                        first_q[i] <= LAST_ENT;
                    end
                    ent_q     <= '0;
                    nv_acc_q  <= '0;
                    err_acc_q <= 1'b0;
                    state_q   <= S_SCAN;
                end
                S_SCAN: begin
                    if (cur_valid) begin
                        votes_q[cur_idx] <= votes_q[cur_idx] + 1'b1;
                        nv_acc_q         <= nv_acc_q + 1'b1;
                        if (votes_q[cur_idx] == '0) begin
                            first_q[cur_idx] <= ent_q;
                        end
                    end else if (!cur_empty) begin
                        // Non-empty entry with an out-of-range label.
                        err_acc_q <= 1'b1;
                    end
                    snap_q <= snap_q << EW;
                    ent_q  <= ent_q + 1'b1;
                    if (ent_q == LAST_ENT) begin
                        cls_q        <= '0;
                        best_cls_q   <= '0;
                        best_cnt_q   <= '0;
                        best_first_q <= '0;
                        state_q      <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    best_cls_q   <= best_cls_d;
                    best_cnt_q   <= best_cnt_d;
                    best_first_q <= best_first_d;
                    cls_q        <= cls_q + 1'b1;
                    if (cls_q == LAST_CLS) begin
                        label_q   <= C'(best_cls_d);
                        n_valid_q <= nv_acc_q;
                        err_q     <= err_acc_q;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign label_out = label_q;
    assign n_valid   = n_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed table-driven bench for knn_vote plus hand-written
// sequences for held start, list changes during a run and mid-run reset.
module tb_knn_vote;

    localparam int DATA_W = 32;
    localparam int C      = 8;
    localparam int K      = 4;
    localparam int NCLASS = 16;
    localparam int LW     = K * (DATA_W + C);
    localparam int LAT    = K + NCLASS + 2;
    localparam logic [31:0] E = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] nb_list = '0;
    logic          busy;
    logic          done;
    logic [C-1:0]  label_out;
    logic [2:0]    n_valid;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [LW-1:0] nb;
        int            exp_label;
        int            exp_nv;
        int            exp_err;
    } vec_t;

    vec_t vecs [10];

    knn_vote #(
        .DATA_W(DATA_W),
        .C(C),
        .K(K),
        .NCLASS(NCLASS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .nb_list(nb_list),
        .busy(busy),
        .done(done),
        .label_out(label_out),
        .n_valid(n_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    // Entry 0 (nearest) occupies the top bits of the list.
    function automatic logic [LW-1:0] mk_nb(input logic [31:0] d0, d1, d2, d3,
                                            input logic [7:0] l0, l1, l2, l3);
        logic [LW-1:0] r;
        r = {d0, l0, d1, l1, d2, l2, d3, l3};
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // One full classification: start driven just after edge T0, accepted at
    // edge T0+1; done expected in cycle LAT, busy over cycles 1..LAT.
    task automatic run_class(input string nm, input logic [LW-1:0] nb,
                             input bit alt_en, input logic [LW-1:0] alt,
                             input int el, input int enr, input int ee);
        int done_at;
        int n_done;
        int busy_bad;
        logic [31:0] got_l;
        logic [31:0] got_nv;
        logic [31:0] got_e;
        done_at  = -1;
        n_done   = 0;
        busy_bad = 0;
        got_l    = 32'hDEAD;
        got_nv   = 32'hDEAD;
        got_e    = 32'hDEAD;
        @(posedge clk);
        #1;
        nb_list = nb;
        start   = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) start = 1'b0;
            if (alt_en && (n == 1 || n == 3)) nb_list = alt;
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = n;
                    got_l   = 32'(label_out);
                    got_nv  = 32'(n_valid);
                    got_e   = 32'(err);
                end
            end
            if (busy !== (n <= LAT)) busy_bad++;
        end
        check({nm, ".done_cycle"}, done_at, LAT);
        check({nm, ".done_count"}, n_done, 1);
        check({nm, ".busy_window_errs"}, busy_bad, 0);
        check({nm, ".label"}, got_l, el);
        check({nm, ".n_valid"}, got_nv, enr);
        check({nm, ".err"}, got_e, ee);
        check({nm, ".label_held"}, 32'(label_out), el);
    endtask

    initial begin
        int n_done;
        int d_at [4];

        vecs[0] = '{mk_nb(10, 20, 30, 40, 3, 3, 5, 7), 3, 4, 0};
        vecs[1] = '{mk_nb(1, 2, 3, 4, 5, 3, 3, 5), 5, 4, 0};
        vecs[2] = '{mk_nb(1, 2, 3, 4, 3, 5, 5, 3), 3, 4, 0};
        vecs[3] = '{mk_nb(7, E, E, E, 9, 0, 0, 0), 9, 1, 0};
        vecs[4] = '{mk_nb(E, E, E, E, 20, 20, 3, 3), 0, 0, 0};
        vecs[5] = '{mk_nb(11, 12, 13, 14, 2, 20, 4, 4), 4, 3, 1};
        vecs[6] = '{mk_nb(100, 200, 300, 400, 1, 2, 2, 6), 2, 4, 0};
        vecs[7] = '{mk_nb(5, 6, 7, 8, 15, 16, 15, 0), 15, 3, 1};
        vecs[8] = '{mk_nb(1, 2, 3, 4, 6, 4, 9, 1), 6, 4, 0};
        vecs[9] = '{mk_nb(32'hFFFF_FFFE, E, E, E, 11, 2, 2, 2), 11, 1, 0};

        // Reset state.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.busy", 32'(busy), 0);
        check("reset.done", 32'(done), 0);
        check("reset.label", 32'(label_out), 0);
        check("reset.n_valid", 32'(n_valid), 0);
        check("reset.err", 32'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_class($sformatf("vec%0d", i), vecs[i].nb, 1'b0, '0,
                      vecs[i].exp_label, vecs[i].exp_nv, vecs[i].exp_err);
        end

        // List changes right after acceptance and during SCAN are ignored.
        run_class("list_change", mk_nb(10, 20, 30, 40, 3, 3, 5, 7), 1'b1,
                  mk_nb(1, 2, 3, 4, 9, 9, 9, 9), 3, 4, 0);

        // Start held high for 30 cycles: accepts at edges 1 and 1+K+NCLASS+3.
        n_done = 0;
        @(posedge clk);
        #1;
        nb_list = mk_nb(1, 2, 3, 4, 1, 1, 2, 2);
        start   = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk);
            #1;
            if (n == 30) start = 1'b0;
            @(negedge clk);
            if (done === 1'b1) begin
                if (n_done < 4) d_at[n_done] = n;
                n_done++;
            end
        end
        check("held.done_count", n_done, 2);
        check("held.first_done", d_at[0], LAT);
        check("held.second_done", d_at[1], LAT + K + NCLASS + 3);
        check("held.label", 32'(label_out), 1);

        // Reset asserted during SCAN aborts the run with no done.
        @(posedge clk);
        #1;
        nb_list = mk_nb(10, 20, 30, 40, 3, 3, 5, 7);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort.busy", 32'(busy), 0);
        check("abort.done", 32'(done), 0);
        check("abort.label", 32'(label_out), 0);
        check("abort.n_valid", 32'(n_valid), 0);
        check("abort.err", 32'(err), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        n_done = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("abort.no_done", n_done, 0);
        run_class("post_reset", mk_nb(5, 6, 7, 8, 1, 1, 1, 1), 1'b0, '0, 1, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
